// File: rtl/router_flit_deserializer_pkg.sv
// router_pkg: shared flit layout constants, deserializer FSM states and saturating counter helper
package router_pkg;
    localparam int FLIT_TAIL_BIT = 0;
    localparam int FLIT_DATA_W_DEF = 10;
    typedef enum logic {HDR, DATA} state_t;
    // Increments v unless it already holds the all-ones value of a w-bit counter (w <= 64)
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] ones;
        ones = {64{1'b1}} >> (64 - w);
        return (v == ones) ? v : v + 64'd1;
    endfunction
endpackage

// File: rtl/router_flit_deserializer_assembler.sv
// flit_word_assembler: MSB-first shift register plus flit index for one core word
// Ports: clk, reset (sync, active-low), shift_en (accept din), clear (drop partial word),
//        din (flit payload), word (assembly contents including din), last (idx is final flit)
module flit_word_assembler #(
    parameter int FLIT_DATA_W = 10,
    parameter int FLITS_PER_WORD = 3,
    localparam int W = FLIT_DATA_W * FLITS_PER_WORD,
    localparam int IDX_W = (FLITS_PER_WORD > 1) ? $clog2(FLITS_PER_WORD) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   shift_en,
    input  logic                   clear,
    input  logic [FLIT_DATA_W-1:0] din,
    output logic [W-1:0]           word,
    output logic                   last
);
    logic [W-1:0]     sr;
    logic [IDX_W-1:0] idx;
    // word already includes the flit being popped, so the top can load it on the same edge
    assign word = W'({sr, din});
    assign last = idx == IDX_W'(FLITS_PER_WORD - 1);
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            sr  <= '0;
            idx <= '0;
        end else if (shift_en) begin
            sr  <= word;
            idx <= last ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/router_flit_deserializer.sv
// router_flit_deserializer: strips worm headers and packs data flits into core words
// Ports: clk, reset (sync, active-low); fifo_empty/fifo_data/fifo_rdreq show-ahead FIFO side;
//        out_d/out_v/out_a core word channel; word_cnt/err_cnt/hdr_nz_cnt saturating status
module router_flit_deserializer
    import router_pkg::*;
#(
    parameter int FLIT_DATA_W = FLIT_DATA_W_DEF,
    parameter int FLITS_PER_WORD = 3,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic [FLIT_DATA_W:0] fifo_data,
    output logic                 fifo_rdreq,
    output logic [OUT_W-1:0]     out_d,
    output logic                 out_v,
    input  logic                 out_a,
    output logic [CNT_W-1:0]     word_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     hdr_nz_cnt
);
    localparam int WORD_W = FLIT_DATA_W * FLITS_PER_WORD;
    state_t                 state, state_nx;
    logic [FLIT_DATA_W-1:0] payload;
    logic [WORD_W-1:0]      word;
    logic                   tail, last, accept, hdr_pop, shift_en, clear, load;
    assign payload = fifo_data[FLIT_DATA_W:1];
    assign tail    = fifo_data[FLIT_TAIL_BIT];
    flit_word_assembler #(
        .FLIT_DATA_W   (FLIT_DATA_W),
        .FLITS_PER_WORD(FLITS_PER_WORD)
    ) u_asm (
        .clk     (clk),
        .reset   (reset),
        .shift_en(shift_en),
        .clear   (clear),
        .din     (payload),
        .word    (word),
        .last    (last)
    );
    // Only a word-completing flit waits for the output buffer to be free or draining
    always_comb begin
        accept     = (state == HDR) || !last || !out_v || out_a;
        fifo_rdreq = reset && !fifo_empty && accept;
        hdr_pop    = fifo_rdreq && (state == HDR);
        shift_en   = fifo_rdreq && (state == DATA);
        clear      = shift_en && !last && tail;
        load       = shift_en && last;
        state_nx   = hdr_pop ? (tail ? HDR : DATA) : (shift_en && tail) ? HDR : state;
    end
    always_ff @(posedge clk) begin
        if (!reset)
            state <= HDR;
        else
            state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_d      <= '0;
            out_v      <= 1'b0;
            word_cnt   <= '0;
            err_cnt    <= '0;
            hdr_nz_cnt <= '0;
        end else begin
            if (load)
                out_d <= OUT_W'(word);
            out_v <= load || (out_v && !out_a);
            if (out_v && out_a)
                word_cnt <= CNT_W'(sat_inc(64'(word_cnt), CNT_W));
            if (clear)
                err_cnt <= CNT_W'(sat_inc(64'(err_cnt), CNT_W));
            if (hdr_pop && payload != '0)
                hdr_nz_cnt <= CNT_W'(sat_inc(64'(hdr_nz_cnt), CNT_W));
        end
    end
endmodule

// File: tb/tb_router_flit_deserializer.sv
// tb_router_flit_deserializer: directed self-checking bench for default and 1-flit-per-word configs
module tb_router_flit_deserializer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        fifo_empty, fifo_rdreq, out_v;
    logic        out_a = 1'b1;
    logic [10:0] fifo_data;
    logic [31:0] out_d;
    logic [15:0] word_cnt, err_cnt, hdr_nz_cnt;
    logic [10:0] mem [0:255];
    logic [7:0]  rp = 8'd0, wp = 8'd0;
    assign fifo_empty = rp == wp;
    assign fifo_data  = mem[rp];

    logic        fifo_empty1, fifo_rdreq1, out_v1;
    logic        out_a1 = 1'b1;
    logic [16:0] fifo_data1;
    logic [15:0] out_d1;
    logic [15:0] word_cnt1, err_cnt1, hdr_nz_cnt1;
    logic [16:0] mem1 [0:255];
    logic [7:0]  rp1 = 8'd0, wp1 = 8'd0;
    assign fifo_empty1 = rp1 == wp1;
    assign fifo_data1  = mem1[rp1];

    router_flit_deserializer dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rdreq(fifo_rdreq), .out_d(out_d), .out_v(out_v), .out_a(out_a),
        .word_cnt(word_cnt), .err_cnt(err_cnt), .hdr_nz_cnt(hdr_nz_cnt)
    );
    router_flit_deserializer #(.FLIT_DATA_W(16), .FLITS_PER_WORD(1), .OUT_W(16)) dut1 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty1), .fifo_data(fifo_data1),
        .fifo_rdreq(fifo_rdreq1), .out_d(out_d1), .out_v(out_v1), .out_a(out_a1),
        .word_cnt(word_cnt1), .err_cnt(err_cnt1), .hdr_nz_cnt(hdr_nz_cnt1)
    );

    logic [31:0] cap [0:63];
    logic [15:0] cap1 [0:63];
    int          cap1_cyc [0:63];
    int          ncap = 0, ncap1 = 0, cyc = 0;
    int          n_chk = 0, n_fail = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rdreq) rp <= rp + 8'd1;
        if (fifo_rdreq1) rp1 <= rp1 + 8'd1;
        if (out_v && out_a) begin
            cap[ncap] <= out_d;
            ncap <= ncap + 1;
        end
        if (out_v1 && out_a1) begin
            cap1[ncap1] <= out_d1;
            cap1_cyc[ncap1] <= cyc;
            ncap1 <= ncap1 + 1;
        end
    end

    task automatic push(input logic [9:0] d, input logic t);
        mem[wp] = {d, t};
        wp = wp + 8'd1;
    endtask

    task automatic push1(input logic [15:0] d, input logic t);
        mem1[wp1] = {d, t};
        wp1 = wp1 + 8'd1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wait_cyc(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        push(10'h000, 1'b1);
        wait_cyc(2);
        n_chk++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL reset_out_v got %b want 0", out_v); end
        n_chk++; if (out_d !== 32'h0) begin n_fail++; $display("FAIL reset_out_d got %h want 0", out_d); end
        n_chk++; if (fifo_rdreq !== 1'b0) begin n_fail++; $display("FAIL reset_rdreq got %b want 0", fifo_rdreq); end
        n_chk++; if ({word_cnt, err_cnt, hdr_nz_cnt} !== 48'h0) begin n_fail++; $display("FAIL reset_cnts got %h want 0", {word_cnt, err_cnt, hdr_nz_cnt}); end
        n_chk++; if (out_v1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_v1 got %b want 0", out_v1); end
        reset = 1'b1;
        wait_cyc(2);
        n_chk++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty_worm got empty=%b want 1", fifo_empty); end
        n_chk++; if ({out_v, err_cnt} !== 17'h0) begin n_fail++; $display("FAIL reset_empty_worm_out got %h want 0", {out_v, err_cnt}); end
    endtask

    task automatic test_single_word();
        int base;
        do_reset();
        out_a = 1'b1;
        base = ncap;
        push(10'h000, 1'b0); push(10'h3FF, 1'b0); push(10'h001, 1'b0); push(10'h2AA, 1'b1);
        wait_cyc(3);
        n_chk++; if ({out_v, fifo_rdreq} !== 2'b01) begin n_fail++; $display("FAIL single_pre got v/rdreq=%b want 01", {out_v, fifo_rdreq}); end
        wait_cyc(1);
        n_chk++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL single_latency got out_v=%b want 1", out_v); end
        n_chk++; if (out_d !== 32'h3FF006AA) begin n_fail++; $display("FAIL single_data got %h want 3ff006aa", out_d); end
        wait_cyc(1);
        n_chk++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL single_clear got out_v=%b want 0", out_v); end
        n_chk++; if (word_cnt !== 16'd1 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL single_cnts got word=%0d err=%0d want 1 0", word_cnt, err_cnt); end
        n_chk++; if (ncap !== base + 1) begin n_fail++; $display("FAIL single_xfers got %0d want %0d", ncap - base, 1); end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        out_a = 1'b0;
        base = ncap;
        push(10'h000, 1'b0);
        push(10'h001, 1'b0); push(10'h002, 1'b0); push(10'h003, 1'b0);
        push(10'h3FF, 1'b0); push(10'h000, 1'b0); push(10'h155, 1'b1);
        wait_cyc(10);
        n_chk++; if (out_v !== 1'b1 || out_d !== 32'h00100803) begin n_fail++; $display("FAIL b2b_hold got v=%b d=%h want 1 00100803", out_v, out_d); end
        n_chk++; if (fifo_rdreq !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got rdreq=%b want 0", fifo_rdreq); end
        n_chk++; if (wp - rp !== 8'd1) begin n_fail++; $display("FAIL b2b_left got %0d flits want 1", wp - rp); end
        out_a = 1'b1;
        wait_cyc(1);
        n_chk++; if (out_v !== 1'b1 || out_d !== 32'h3FF00155) begin n_fail++; $display("FAIL b2b_reload got v=%b d=%h want 1 3ff00155", out_v, out_d); end
        n_chk++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_drain got empty=%b want 1", fifo_empty); end
        wait_cyc(1);
        n_chk++; if (ncap !== base + 2) begin n_fail++; $display("FAIL b2b_xfers got %0d want 2", ncap - base); end
        n_chk++; if (cap[base] !== 32'h00100803 || cap[base+1] !== 32'h3FF00155) begin n_fail++; $display("FAIL b2b_order got %h %h want 00100803 3ff00155", cap[base], cap[base+1]); end
        n_chk++; if (word_cnt !== 16'd2 || out_v !== 1'b0) begin n_fail++; $display("FAIL b2b_cnt got word=%0d v=%b want 2 0", word_cnt, out_v); end
    endtask

    task automatic test_premature_tail();
        int base;
        do_reset();
        out_a = 1'b1;
        base = ncap;
        push(10'h000, 1'b0); push(10'h005, 1'b0); push(10'h006, 1'b1);
        push(10'h000, 1'b0); push(10'h001, 1'b0); push(10'h002, 1'b0); push(10'h003, 1'b1);
        wait_cyc(12);
        n_chk++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL premature_err got %0d want 1", err_cnt); end
        n_chk++; if (ncap !== base + 1 || word_cnt !== 16'd1) begin n_fail++; $display("FAIL premature_words got %0d/%0d want 1", ncap - base, word_cnt); end
        n_chk++; if (cap[base] !== 32'h00100803) begin n_fail++; $display("FAIL premature_data got %h want 00100803", cap[base]); end
    endtask

    task automatic test_hdr_nonzero();
        int base;
        do_reset();
        base = ncap;
        push(10'h155, 1'b1);
        push(10'h000, 1'b0); push(10'h3FF, 1'b0); push(10'h001, 1'b0); push(10'h2AA, 1'b1);
        wait_cyc(10);
        n_chk++; if (hdr_nz_cnt !== 16'd1) begin n_fail++; $display("FAIL hdrnz_cnt got %0d want 1", hdr_nz_cnt); end
        n_chk++; if (ncap !== base + 1 || cap[base] !== 32'h3FF006AA) begin n_fail++; $display("FAIL hdrnz_word got n=%0d d=%h want 1 3ff006aa", ncap - base, cap[base]); end
        n_chk++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL hdrnz_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_mid_reset();
        int base;
        do_reset();
        out_a = 1'b0;
        push(10'h001, 1'b0);
        push(10'h111, 1'b0); push(10'h222, 1'b0); push(10'h333, 1'b0); push(10'h044, 1'b0);
        wait_cyc(8);
        n_chk++; if (out_v !== 1'b1 || hdr_nz_cnt !== 16'd1 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_setup got v=%b hnz=%0d empty=%b want 1 1 1", out_v, hdr_nz_cnt, fifo_empty); end
        reset = 1'b0;
        wait_cyc(1);
        n_chk++; if (out_v !== 1'b0 || fifo_rdreq !== 1'b0) begin n_fail++; $display("FAIL midrst_out got v=%b rdreq=%b want 0 0", out_v, fifo_rdreq); end
        n_chk++; if ({word_cnt, err_cnt, hdr_nz_cnt} !== 48'h0) begin n_fail++; $display("FAIL midrst_cnts got %h want 0", {word_cnt, err_cnt, hdr_nz_cnt}); end
        reset = 1'b1;
        out_a = 1'b1;
        base = ncap;
        push(10'h000, 1'b0); push(10'h3FF, 1'b0); push(10'h001, 1'b0); push(10'h2AA, 1'b1);
        wait_cyc(8);
        n_chk++; if (ncap !== base + 1 || cap[base] !== 32'h3FF006AA) begin n_fail++; $display("FAIL midrst_clean got n=%0d d=%h want 1 3ff006aa", ncap - base, cap[base]); end
        n_chk++; if (err_cnt !== 16'd0 || word_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_clean_cnts got err=%0d word=%0d want 0 1", err_cnt, word_cnt); end
    endtask

    task automatic test_one_flit_word();
        logic [15:0] exp [0:3];
        int base;
        exp[0] = 16'h1234; exp[1] = 16'hABCD; exp[2] = 16'h0000; exp[3] = 16'hFFFF;
        do_reset();
        out_a1 = 1'b1;
        base = ncap1;
        push1(16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) push1(exp[i], i == 3);
        wait_cyc(8);
        n_chk++; if (ncap1 !== base + 4 || word_cnt1 !== 16'd4) begin n_fail++; $display("FAIL fpw1_count got n=%0d cnt=%0d want 4", ncap1 - base, word_cnt1); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (cap1[base+i] !== exp[i]) begin n_fail++; $display("FAIL fpw1_word%0d got %h want %h", i, cap1[base+i], exp[i]); end
        end
        for (int i = 1; i < 4; i++) begin
            n_chk++; if (cap1_cyc[base+i] !== cap1_cyc[base] + i) begin n_fail++; $display("FAIL fpw1_rate%0d got cycle %0d want %0d", i, cap1_cyc[base+i], cap1_cyc[base] + i); end
        end
        n_chk++; if (err_cnt1 !== 16'd0 || out_v1 !== 1'b0) begin n_fail++; $display("FAIL fpw1_end got err=%0d v=%b want 0 0", err_cnt1, out_v1); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_premature_tail();
        test_hdr_nonzero();
        test_mid_reset();
        test_one_flit_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/router_flit_deserializer.md
# router_flit_deserializer

Parametrised replacement for the fixed 3-flit BZ word deserializer. It pops router flits from a show-ahead FIFO, discards each worm's header flit, and assembles FLITS_PER_WORD data flits MSB-first into one core word. Each word goes out on a valid/ack channel to the core. It adds multi-word worm support, a one-word output buffer so the next word can assemble during a stalled handshake, framing-error detection, and status counters. It sits between the router-side input FIFO and the core input channel.

## Interface
- FLIT_DATA_W, 10, payload bits per flit (route or data field).
- FLITS_PER_WORD, 3, data flits per core word; at least 1.
- OUT_W, 32, core word width; at least FLIT_DATA_W*FLITS_PER_WORD; upper bits zero-filled.
- CNT_W, 16, width of the status counters.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- fifo_empty  in  1  input FIFO empty.
- fifo_data  in  FLIT_DATA_W+1  show-ahead head flit: [FLIT_DATA_W:1] payload, [0] tail.
- fifo_rdreq  out  1  pop head flit this cycle.
- out_d  out  OUT_W  assembled word.
- out_v  out  1  out_d valid.
- out_a  in  1  core accept; a transfer occurs on a clk edge where out_v && out_a.
- word_cnt  out  CNT_W  words transferred; saturating.
- err_cnt  out  CNT_W  framing errors; saturating.
- hdr_nz_cnt  out  CNT_W  header flits with a nonzero route field; saturating.

## Operation
- Worm format: 1 header flit, then k≥0 words of FLITS_PER_WORD data flits each. The tail bit is set only on the worm's last flit.
- The header flit is consumed and discarded.
  - A nonzero route field increments hdr_nz_cnt; the flit is still treated as the header.
  - A header with tail=1 is a legal empty worm: discarded, no error, next state HDR.
- State machine: HDR and DATA, plus flit index idx in 0..FLITS_PER_WORD-1.
  - HDR, on pop: go to DATA with idx=0, unless tail=1 (stay in HDR).
  - DATA, on pop: shift the payload into the assembly register MSB-first.
    - If idx < last and tail=1: premature tail. Discard the partial word, increment err_cnt, go to HDR.
    - If idx < last and tail=0: idx+1.
    - If idx == last: load the completed word into the output buffer and set out_v. Go to HDR if tail=1; otherwise stay in DATA with idx=0.
- Missing tail is not detectable; the next flit is treated as data.
- Accept rule: fifo_rdreq = !fifo_empty && accept.
  - accept is 1 in HDR.
  - accept is 1 in DATA with idx < last.
  - accept is 1 at idx == last only if !out_v || out_a, meaning the buffer is free or draining this cycle.
- Output buffer: out_d and out_v hold stable until the transfer edge. The transfer clears out_v unless a new word loads on the same edge; in that case out_v stays 1 with the new out_d.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values (clk edge with reset=0): state HDR, idx 0, out_v 0, out_d 0, all counters 0, assembly register 0.
  - fifo_rdreq is combinational, so it is 0 while reset=0.
- Reset mid-worm or mid-handshake: the partial word and any pending output word are dropped; out_v is 0 after the edge.
- Pop and capture happen in the same cycle, with no FIFO read latency.
- Latency: last data flit popped at edge N gives out_v=1 after edge N.
- Throughput: 1 flit/cycle. With out_a held at 1, one word per FLITS_PER_WORD cycles with no bubble, plus one cycle per header.
- Backpressure: only the last flit of a word stalls. Earlier flits keep popping while out_v is pending.

## Structure
- Shared package router_pkg holds:
  - FLIT_TAIL_BIT position and the default FLIT_DATA_W.
  - The state enum {HDR, DATA}.
  - A saturating-increment function for the counters.
- Sub-module flit_word_assembler: the shift register and idx counter, with inputs shift_en and clear and outputs word and last.
- Top level holds the FSM, output buffer and counters.

## Test plan
- Defaults; header 0x000/t0, flits 0x3FF/t0, 0x001/t0, 0x2AA/t1; out_a=1 -> out_v one cycle after the last pop, out_d=0x3FF006AA, word_cnt=1, err_cnt=0.
- Two-word worm (header plus 6 data flits, tail on the 6th) with out_a=0 until both words are ready -> the second word's last flit is not popped while out_v=1. Raise out_a -> 2 transfers in order, word_cnt=2, no flit lost.
- Premature tail: header, 0x005/t0, 0x006/t1, then header, 0x001/t0, 0x002/t0, 0x003/t1 -> err_cnt=1, single output 0x00100803.
- Header 0x155/t1, then header 0x000/t0 plus a normal word -> hdr_nz_cnt=1, exactly one word output, err_cnt=0.
- reset=0 asserted while out_v=1 and idx=1 -> next cycle out_v=0, fifo_rdreq=0, counters 0. The following clean worm is assembled correctly.
- FLITS_PER_WORD=1, FLIT_DATA_W=16, OUT_W=16; a 4-word worm with out_a=1 -> one word per cycle after the header, word_cnt=4.
